// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready link from the host into the loader
//   rx_data  [7:0] program byte, driven by the host
//   rx_valid       rx_data valid, driven by the host
//   rx_ready       loader accepts a byte, driven by the loader
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    modport master (output rx_data, rx_valid, input rx_ready);
    modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a byte-stream program image into instruction RAM, then serves Instr to the core
//   clk           system clock
//   reset         asynchronous active-low reset
//   rx            byte link (slave side): rx_data / rx_valid / rx_ready
//   reload        synchronous restart of loading, level-sampled, beats any byte
//   PC / Instr    core program counter and combinational instruction
//   cpu_reset     active-high core reset, released only in RUN
//   load_done     image loaded and core running
//   load_error    bad header (or bad checksum trailer)
//   words_loaded  words written in the current load
// Optional feature: define IMEM_CHECKSUM_EN to require an XOR trailer byte after the payload.
module imem_loader #(
    parameter int  DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                reset,
    imem_loader_if.slave        rx,
    input  logic                reload,
    input  logic [31:0]         PC,
    output logic [31:0]         Instr,
    output logic                cpu_reset,
    output logic                load_done,
    output logic                load_error,
    output logic [15:0]         words_loaded
);
`ifdef IMEM_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef enum logic [2:0] {HDR_LO, HDR_HI, LOAD, RUN, ERROR} state_t;

    state_t      state;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [23:0] sbuf;
    logic [7:0]  csum;
    logic [31:0] mem [DEPTH_WORDS];

    logic          acc, trailer, we, hit, unused_pc;
    logic [15:0]   new_count;
    logic [AW-1:0] idx;

    assign rx.rx_ready  = (state == HDR_LO || state == HDR_HI || state == LOAD) && !reload;
    assign cpu_reset    = state != RUN;
    assign load_done    = state == RUN;
    assign load_error   = state == ERROR;
    assign acc          = rx.rx_valid && rx.rx_ready;
    assign new_count    = {rx.rx_data, count[7:0]};
    // With the checksum enabled, the byte after the last payload word is the trailer
    assign trailer      = CHK && words_loaded == count;
    assign we           = acc && state == LOAD && !trailer && byte_idx == 2'd3;
    assign idx          = PC[AW+1:2];
    assign hit          = state == RUN && PC[31:AW+2] == '0 && 32'(idx) < 32'(count);
    assign Instr        = hit ? mem[idx] : 32'h0000_0000;
    assign unused_pc    = ^PC[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= HDR_LO;
            count        <= '0;
            byte_idx     <= '0;
            sbuf         <= '0;
            csum         <= '0;
            words_loaded <= '0;
        end else if (reload) begin
            state        <= HDR_LO;
            count        <= '0;
            byte_idx     <= '0;
            sbuf         <= '0;
            csum         <= '0;
            words_loaded <= '0;
        end else if (acc) begin
            case (state)
                HDR_LO: begin
                    count[7:0] <= rx.rx_data;
                    state      <= HDR_HI;
                end
                HDR_HI: begin
                    count[15:8] <= rx.rx_data;
                    state       <= (new_count == 16'd0 || 32'(new_count) > DEPTH_WORDS) ? ERROR : LOAD;
                end
                LOAD: begin
                    if (trailer) begin
                        state <= rx.rx_data == csum ? RUN : ERROR;
                    end else begin
                        csum <= csum ^ rx.rx_data;
                        // Little-endian assembly: bytes shift in from the top, so after three
                        // bytes sbuf holds {b2, b1, b0} and the fourth byte completes the word
                        if (byte_idx == 2'd3) begin
                            byte_idx     <= '0;
                            words_loaded <= words_loaded + 16'd1;
                            if (!CHK && words_loaded + 16'd1 == count)
                                state <= RUN;
                        end else begin
                            sbuf     <= {rx.rx_data, sbuf[23:8]};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is not reset; stale words stay unreachable through the count check on Instr
    always_ff @(posedge clk) begin
        if (we)
            mem[words_loaded[AW-1:0]] <= {rx.rx_data, sbuf};
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader (vector table + word scoreboard)
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reload = 1'b0;
    logic [31:0] PC = 32'd0;
    logic [31:0] Instr;
    logic        cpu_reset, load_done, load_error;
    logic [15:0] words_loaded;

    imem_loader_if intf();

    imem_loader dut (
        .clk(clk), .reset(reset), .rx(intf.slave), .reload(reload), .PC(PC),
        .Instr(Instr), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

`ifdef IMEM_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    typedef struct { logic [31:0] pc; logic [31:0] exp; } vec_t;

    int          passed = 0, total = 0;
    int          acc_cnt = 0, val_cnt = 0;
    logic [31:0] sb[$];
    logic [31:0] img [256];

    always @(posedge clk) begin
        if (intf.rx_valid) val_cnt++;
        if (intf.rx_valid && intf.rx_ready) acc_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int n = 0;
        @(negedge clk);
        if (gap && $urandom_range(1) == 1) begin
            intf.rx_valid = 1'b0;
            @(negedge clk);
        end
        intf.rx_data  = b;
        intf.rx_valid = 1'b1;
        while (!intf.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL send_timeout: byte %h not accepted within 100 cycles", b);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        intf.rx_valid = 1'b0;
    endtask

    task automatic reload_pulse();
        @(negedge clk);
        intf.rx_valid = 1'b0;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        #1;
    endtask

    task automatic load(input int n, input bit gap);
        logic [7:0] x = 8'h00;
        logic [31:0] w;
        logic [15:0] c;
        c = n[15:0];
        PC = 32'd0;
        send(c[7:0], gap);
        send(c[15:8], gap);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                send(w[8*k +: 8], gap);
                x = x ^ w[8*k +: 8];
            end
            sb.push_back(w);
            if (gap && i < n - 1) begin
                #1;
                chk("instr_before_run", Instr, 32'h0);
            end
        end
        if (CHK != 0) send(x, gap);
        idle();
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() > 0) begin
            PC = 32'(4 * i);
            #1;
            chk($sformatf("ram_word[%0d]", i), Instr, sb.pop_front());
            i++;
        end
        PC = 32'd0;
        #1;
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 32'(intf.rx_ready), 32'd1);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_error"}, 32'(load_error), 32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
        chk({tag, "_instr"}, Instr, 32'd0);
    endtask

    initial begin
        vec_t tv[6];
        int   a0, v0;
        tv[0] = '{32'h0000_0000, 32'hE3A0_0000};
        tv[1] = '{32'h0000_0004, 32'hE281_1004};
        tv[2] = '{32'h0000_0008, 32'h0000_0000};
        tv[3] = '{32'h0000_0006, 32'hE281_1004};
        tv[4] = '{32'h0000_0003, 32'hE3A0_0000};
        tv[5] = '{32'h1000_0000, 32'h0000_0000};
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        img[0] = 32'hE3A0_0000;
        img[1] = 32'hE281_1004;
        intf.rx_valid = 1'b0;
        intf.rx_data  = 8'h00;

        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset_outputs("por");
        reset = 1'b1;

        // two-word program, valid held high
        a0 = acc_cnt;
        v0 = val_cnt;
        load(2, 1'b0);
        chk("accepts", 32'(acc_cnt - a0), 32'(10 + CHK));
        chk("valid_cycles", 32'(val_cnt - v0), 32'(10 + CHK));
        chk("run_rx_ready", 32'(intf.rx_ready), 32'd0);
        chk("run_load_done", 32'(load_done), 32'd1);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run_words", 32'(words_loaded), 32'd2);
        for (int i = 0; i < 6; i++) begin
            PC = tv[i].pc;
            #1;
            chk($sformatf("vec[%0d]", i), Instr, tv[i].exp);
        end
        sb.delete();

        // reload from RUN, then zero-count header
        PC = 32'd0;
        reload_pulse();
        reset_outputs("reload");
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        idle();
        chk("zero_load_error", 32'(load_error), 32'd1);
        chk("zero_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("zero_rx_ready", 32'(intf.rx_ready), 32'd0);
        reload_pulse();
        chk("clr_load_error", 32'(load_error), 32'd0);
        chk("clr_rx_ready", 32'(intf.rx_ready), 32'd1);

        // reload beats a simultaneous byte
        @(negedge clk);
        reload = 1'b1;
        intf.rx_valid = 1'b1;
        intf.rx_data = 8'h55;
        #1;
        chk("reload_blocks_ready", 32'(intf.rx_ready), 32'd0);
        @(negedge clk);
        reload = 1'b0;
        intf.rx_valid = 1'b0;
        load(1, 1'b0);
        chk("prio_load_done", 32'(load_done), 32'd1);
        chk("prio_words", 32'(words_loaded), 32'd1);
        drain();

        // count 257 rejected, count 256 fills the RAM
        reload_pulse();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        idle();
        chk("over_load_error", 32'(load_error), 32'd1);
        reload_pulse();
        load(256, 1'b0);
        chk("full_words", 32'(words_loaded), 32'd256);
        chk("full_load_done", 32'(load_done), 32'd1);
        PC = 32'h0000_03FC;
        #1;
        chk("full_last_word", Instr, img[255]);
        PC = 32'h0000_0400;
        #1;
        chk("full_past_end", Instr, 32'h0);
        drain();

        // three words with random valid gaps; stale RAM beyond count unreachable
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        reload_pulse();
        load(3, 1'b1);
        chk("gap_words", 32'(words_loaded), 32'd3);
        PC = 32'd12;
        #1;
        chk("gap_stale_hidden", Instr, 32'h0);
        drain();

        // asynchronous reset after five payload bytes
        reload_pulse();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) send(8'(k + 1), 1'b0);
        send(8'hAA, 1'b0);
        @(negedge clk);
        chk("pre_reset_words", 32'(words_loaded), 32'd1);
        intf.rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        reset_outputs("async");
        @(negedge clk);
        reset = 1'b1;
        img[0] = 32'hCAFE_F00D;
        load(1, 1'b0);
        chk("fresh_load_done", 32'(load_done), 32'd1);
        drain();

`ifdef IMEM_CHECKSUM_EN
        for (int t = 0; t < 2; t++) begin
            reload_pulse();
            send(8'h01, 1'b0);
            send(8'h00, 1'b0);
            send(8'h11, 1'b0);
            send(8'h22, 1'b0);
            send(8'h44, 1'b0);
            send(8'h88, 1'b0);
            #1;
            chk("csum_words_before_trailer", 32'(words_loaded), 32'd1);
            chk("csum_wait_trailer", 32'(load_done), 32'd0);
            send(t == 0 ? 8'hFF : 8'hFE, 1'b0);
            idle();
            chk("csum_load_done", 32'(load_done), t == 0 ? 32'd1 : 32'd0);
            chk("csum_load_error", 32'(load_error), t == 0 ? 32'd0 : 32'd1);
            chk("csum_cpu_reset", 32'(cpu_reset), t == 0 ? 32'd0 : 32'd1);
            chk("csum_instr", Instr, t == 0 ? 32'h8844_2211 : 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
